// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory port.
// DMEM_ARB_LOCK_EN adds the p1_lock request qualifier.
interface dmem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 15
);
  logic          p0_req;
  logic          p0_we;
  logic [15:0]   p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [15:0]   p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          p1_lock;
`endif

  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  p1_lock,
`endif
    output mem_raddr, mem_wen, mem_waddr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
    output p1_lock,
`endif
    input  mem_raddr, mem_wen, mem_waddr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fixed port-0 priority with port-1 starvation aging,
// pipelined read-return routing. Optional DMEM_ARB_LOCK_EN adds a port-1 bus lock.
module dmem_arbiter #(
  parameter int DW         = 16,
  parameter int AW         = 15,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0]       starve_cnt;
  logic                starve_hit;
  logic                locked;
  logic                sel1;
  logic                gnt0;
  logic                gnt1;
  logic                win_we;
  logic                rd_gnt;
  logic                wr_gnt;
  logic [15:0]         win_addr;
  logic [DW-1:0]       win_wdata;
  logic [AW-1:0]       raddr_q;
  logic [READ_LAT-1:0] trk_vld;
  logic [READ_LAT-1:0] trk_own;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = bus.p0_addr[0] ^ bus.p1_addr[0];

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;
  arb_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_OPEN;
    end else begin
      case (state)
        ARB_OPEN:   if (gnt1 && bus.p1_lock) state <= ARB_LOCKED;
        ARB_LOCKED: if (!bus.p1_lock) state <= ARB_OPEN;
        default:    state <= ARB_OPEN;
      endcase
    end
  end

  assign locked = (state == ARB_LOCKED);
`else
  assign locked = 1'b0;
`endif

  assign starve_hit = (STARVE_MAX > 0) && (starve_cnt == STARVE_TOP) && bus.p1_req;

  // Grants are masked by rst_n so nothing is accepted while reset is held.
  always_comb begin
    sel1      = bus.p1_req && (locked || !bus.p0_req || starve_hit);
    gnt1      = rst_n && sel1;
    gnt0      = rst_n && bus.p0_req && !sel1 && !locked;
    win_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    win_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    win_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    wr_gnt    = (gnt0 || gnt1) && win_we;
    rd_gnt    = (gnt0 || gnt1) && !win_we;
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.mem_wen   = wr_gnt;
  assign bus.mem_waddr = win_addr[AW:1];
  assign bus.mem_wdata = win_wdata;
  assign bus.mem_raddr = rd_gnt ? win_addr[AW:1] : raddr_q;

  assign bus.p0_rvalid = rst_n && trk_vld[READ_LAT-1] && !trk_own[READ_LAT-1];
  assign bus.p1_rvalid = rst_n && trk_vld[READ_LAT-1] &&  trk_own[READ_LAT-1];
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      raddr_q    <= '0;
      trk_vld    <= '0;
      trk_own    <= '0;
    end else begin
      if (!bus.p1_req || gnt1 || locked) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_TOP) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (rd_gnt) begin
        raddr_q <= win_addr[AW:1];
      end

      trk_vld[0] <= rd_gnt;
      trk_own[0] <= gnt1;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        trk_vld[i] <= trk_vld[i-1];
        trk_own[i] <= trk_own[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle reference model plus directed literal checks.
module tb_dmem_arbiter;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int READ_LAT = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DW(DW), .AW(AW)) bus();

  dmem_arbiter #(
    .DW(DW), .AW(AW), .READ_LAT(READ_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] memarr [0:32767];
  logic [15:0] rq[$];

  typedef struct {
    int          due;
    logic        own;
    logic [15:0] data;
  } ret_t;
  ret_t pend[$];

  int          cyc = 0;
  int          m_starve = 0;
  logic [14:0] m_raddr = '0;
  logic        w1, w0, e_we;
  logic [15:0] e_addr, e_wdata;
  logic        due_now;

  // Reference model + memory: issue-time capture of memory contents, READ_LAT return.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rq.push_back(memarr[bus.mem_raddr]);
      if (!rst_n) begin
        chk("rst_p0_gnt", 32'(bus.p0_gnt), 0);
        chk("rst_p1_gnt", 32'(bus.p1_gnt), 0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 0);
        chk("rst_p0_rvalid", 32'(bus.p0_rvalid), 0);
        chk("rst_p1_rvalid", 32'(bus.p1_rvalid), 0);
        chk("rst_mem_raddr", 32'(bus.mem_raddr), 0);
        pend.delete();
        m_starve = 0;
        m_raddr = '0;
      end else begin
        w1 = bus.p1_req && (!bus.p0_req || (STARVE_MAX > 0 && m_starve == STARVE_MAX));
        w0 = bus.p0_req && !w1;
        e_we    = w1 ? bus.p1_we    : bus.p0_we;
        e_addr  = w1 ? bus.p1_addr  : bus.p0_addr;
        e_wdata = w1 ? bus.p1_wdata : bus.p0_wdata;
        chk("m_p0_gnt", 32'(bus.p0_gnt), 32'(w0));
        chk("m_p1_gnt", 32'(bus.p1_gnt), 32'(w1));
        chk("m_mem_wen", 32'(bus.mem_wen), 32'((w0 || w1) && e_we));
        if ((w0 || w1) && e_we) begin
          chk("m_mem_waddr", 32'(bus.mem_waddr), 32'(e_addr >> 1));
          chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        end
        chk("m_mem_raddr", 32'(bus.mem_raddr),
            ((w0 || w1) && !e_we) ? 32'(e_addr >> 1) : 32'(m_raddr));
        due_now = (pend.size() > 0) && (pend[0].due == cyc);
        chk("m_p0_rvalid", 32'(bus.p0_rvalid), 32'(due_now && !pend[0].own));
        chk("m_p1_rvalid", 32'(bus.p1_rvalid), 32'(due_now && pend[0].own));
        if (due_now) begin
          if (pend[0].own) chk("m_p1_rdata", 32'(bus.p1_rdata), 32'(pend[0].data));
          else             chk("m_p0_rdata", 32'(bus.p0_rdata), 32'(pend[0].data));
          void'(pend.pop_front());
        end
        if (bus.p1_req && !w1) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else                   m_starve = 0;
        if ((w0 || w1) && !e_we) begin
          pend.push_back('{due: cyc + READ_LAT, own: w1, data: memarr[e_addr >> 1]});
          m_raddr = e_addr[15:1];
        end
        if (bus.mem_wen) memarr[bus.mem_waddr] = bus.mem_wdata;
      end
      @(posedge clk);
      #1;
      if (rq.size() >= READ_LAT) bus.mem_rdata = rq.pop_front();
    end
  end

  task automatic set_in(input logic r0, input logic we0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic r1, input logic we1, input logic [15:0] a1, input logic [15:0] d1);
    bus.p0_req = r0; bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (n) next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) memarr[i] = 16'h5000 ^ 16'(i);
    memarr[8] = 16'h1234;
    memarr[1] = 16'h1111;
    memarr[2] = 16'h2222;
    memarr[3] = 16'h3333;
    memarr[4] = 16'h4444;
    bus.mem_rdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    bus.p1_lock = 1'b0;
`endif

    // Reset held with both ports requesting writes
    set_in(1, 1, 16'h0010, 16'hAAAA, 1, 1, 16'h0020, 16'hBBBB);
    repeat (2) begin
      @(negedge clk);
      chk("t1_p0_gnt_rst", 32'(bus.p0_gnt), 0);
      chk("t1_p1_gnt_rst", 32'(bus.p1_gnt), 0);
      chk("t1_wen_rst", 32'(bus.mem_wen), 0);
    end
    next_cycle();
    rst_n = 1'b1;
    set_in(1, 0, 16'h0030, 16'h0, 1, 0, 16'h0040, 16'h0);
    @(negedge clk);
    chk("t1_p0_gnt_first", 32'(bus.p0_gnt), 1);
    chk("t1_p1_gnt_first", 32'(bus.p1_gnt), 0);
    next_cycle();
    idle(4);

    // Single port-0 read, data returns READ_LAT cycles later
    set_in(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("t2_p0_gnt", 32'(bus.p0_gnt), 1);
    chk("t2_raddr", 32'(bus.mem_raddr), 32'h0008);
    next_cycle();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("t2_rvalid_early", 32'(bus.p0_rvalid), 0);
    next_cycle();
    @(negedge clk);
    chk("t2_p0_rvalid", 32'(bus.p0_rvalid), 1);
    chk("t2_p0_rdata", 32'(bus.p0_rdata), 32'h1234);
    chk("t2_p1_rvalid", 32'(bus.p1_rvalid), 0);
    next_cycle();
    @(negedge clk);
    chk("t2_rvalid_late", 32'(bus.p0_rvalid), 0);
    next_cycle();
    idle(2);

    // Port-1 write with port 0 idle
    set_in(0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'hBEEF);
    @(negedge clk);
    chk("t4_p1_gnt", 32'(bus.p1_gnt), 1);
    chk("t4_wen", 32'(bus.mem_wen), 1);
    chk("t4_waddr", 32'(bus.mem_waddr), 32'h0010);
    chk("t4_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    next_cycle();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_rvalid", 32'(bus.p0_rvalid | bus.p1_rvalid), 0);
      next_cycle();
    end

    // Continuous contention: four port-0 grants then one aged port-1 grant
    set_in(1, 0, 16'h0100, 16'h0, 1, 0, 16'h0200, 16'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_p1_gnt", 32'(bus.p1_gnt), 32'((k % 5) == 4));
      chk("t3_p0_gnt", 32'(bus.p0_gnt), 32'((k % 5) != 4));
      next_cycle();
    end
    idle(4);

    // Alternating reads, returns alternate owners with that cycle's data
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: set_in(1, 0, 16'h0002, 16'h0, 0, 0, 16'h0, 16'h0);
        1: set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0004, 16'h0);
        2: set_in(1, 0, 16'h0006, 16'h0, 0, 0, 16'h0, 16'h0);
        3: set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0008, 16'h0);
        default: set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      endcase
      @(negedge clk);
      if (k >= 2) begin
        chk("t5_p0_rvalid", 32'(bus.p0_rvalid), 32'((k % 2) == 0));
        chk("t5_p1_rvalid", 32'(bus.p1_rvalid), 32'((k % 2) == 1));
        if ((k % 2) == 0) chk("t5_p0_rdata", 32'(bus.p0_rdata), 32'(16'h1111 * 16'(k - 1)));
        else              chk("t5_p1_rdata", 32'(bus.p1_rdata), 32'(16'h1111 * 16'(k - 1)));
      end
      next_cycle();
    end
    idle(2);

    // Two reads in flight, then a one-cycle reset pulse discards them
    set_in(1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0);
    next_cycle();
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0);
    next_cycle();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_in_rst", 32'(bus.p0_rvalid | bus.p1_rvalid), 0);
    next_cycle();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_p0_rvalid", 32'(bus.p0_rvalid), 0);
      chk("t6_p1_rvalid", 32'(bus.p1_rvalid), 0);
      chk("t6_raddr", 32'(bus.mem_raddr), 0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
